// File: rtl/otp_pkg.sv
// Shared constants and helpers for the one-time-pad stream cipher:
// request mode encodings and the Galois LFSR tap table per word width.
package otp_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int unsigned MAX_W = 32;

    // Maximal-length Galois feedback masks, right-shifting form.
    function automatic logic [MAX_W-1:0] lfsr_taps(input int unsigned width);
        logic [MAX_W-1:0] taps;
        taps = '0;
        case (width)
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            32:      taps = 32'h8020_0003;
            default: taps = '0;
        endcase
        return taps;
    endfunction

    function automatic bit legal_width(input int unsigned width);
        return (width == 8) || (width == 16) || (width == 32);
    endfunction

endpackage

// File: rtl/otp_lfsr.sv
// Galois LFSR pad generator; steps once per cycle in which advance is high.
// value is the pad that the next accepted encrypt will consume.
module otp_lfsr
    import otp_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    localparam logic [MAX_W-1:0] TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    // An all-zero state is a fixed point of the register and would emit a constant pad.
    if (SEED == '0) begin : g_bad_seed
        $error("otp_lfsr: SEED must be nonzero");
    end
    if (!legal_width(WIDTH)) begin : g_bad_width
        $error("otp_lfsr: WIDTH must be 8, 16 or 32");
    end

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_next;

    always_comb begin
        state_next = state_q >> 1;
        if (state_q[0]) begin
            state_next = state_next ^ TAPS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else if (advance) begin
            state_q <= state_next;
        end
    end

    assign value = state_q;

endmodule

// File: rtl/otp_stream_cipher.sv
// One-time-pad cipher engine with valid/ready streaming on input and output.
// Define OTP_BURN_EN to enforce single use of each pad slot (burn on decrypt).
module otp_stream_cipher
    import otp_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       PAD_DEPTH = 8,
    parameter logic [DATA_W-1:0] SEED      = 'h1,
    localparam int unsigned      IDX_W     = $clog2(PAD_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DATA_W-1:0] in_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_err,

    output logic [IDX_W:0]    live_count
);

    localparam int unsigned CNT_W = IDX_W + 1;

    if (!legal_width(DATA_W)) begin : g_bad_data_w
        $error("otp_stream_cipher: DATA_W must be 8, 16 or 32");
    end
    if ((PAD_DEPTH < 2) || (PAD_DEPTH > 256) ||
        ((PAD_DEPTH & (PAD_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("otp_stream_cipher: PAD_DEPTH must be a power of two in 2..256");
    end

    logic [DATA_W-1:0]    pad_mem [PAD_DEPTH];
    logic [PAD_DEPTH-1:0] live;
    logic [IDX_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     live_cnt_q;
    logic [DATA_W-1:0]    lfsr_value;

    logic accept;
    logic is_enc;
    logic is_dec;
    logic enc_writable;
    logic dec_readable;
    logic enc_ok;
    logic dec_ok;

    logic [DATA_W-1:0] res_data;
    logic [IDX_W-1:0]  res_index;
    logic              res_err;

    // The output stage frees up whenever it is empty or being drained this cycle.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign is_enc   = accept & (in_mode == MODE_ENC);
    assign is_dec   = accept & (in_mode == MODE_DEC);

`ifdef OTP_BURN_EN
    assign enc_writable = ~live[wr_ptr];
`else
    assign enc_writable = 1'b1;
`endif
    assign dec_readable = live[in_index];

    assign enc_ok = is_enc & enc_writable;
    assign dec_ok = is_dec & dec_readable;

    otp_lfsr #(
        .WIDTH (DATA_W),
        .SEED  (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (enc_ok),
        .value   (lfsr_value)
    );

    always_comb begin
        res_data  = '0;
        res_index = '0;
        res_err   = 1'b0;
        if (in_mode == MODE_ENC) begin
            res_index = wr_ptr;
            if (enc_writable) begin
                res_data = in_data ^ lfsr_value;
            end else begin
                res_err = 1'b1;
            end
        end else begin
            res_index = in_index;
            if (dec_readable) begin
                res_data = in_data ^ pad_mem[in_index];
            end else begin
                res_err = 1'b1;
            end
        end
    end

    // Pad contents are meaningless until their live flag is set, so no reset here.
    always_ff @(posedge clk) begin
        if (enc_ok) begin
            pad_mem[wr_ptr] <= lfsr_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            live   <= '0;
        end else begin
            if (enc_ok) begin
                wr_ptr       <= wr_ptr + IDX_W'(1);
                live[wr_ptr] <= 1'b1;
            end
`ifdef OTP_BURN_EN
            if (dec_ok) begin
                live[in_index] <= 1'b0;
            end
`endif
        end
    end

    // Count tracks popcount(live): only a write into a dead slot adds, only a burn removes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_cnt_q <= '0;
        end else if (enc_ok && !live[wr_ptr]) begin
            live_cnt_q <= live_cnt_q + CNT_W'(1);
`ifdef OTP_BURN_EN
        end else if (dec_ok) begin
            live_cnt_q <= live_cnt_q - CNT_W'(1);
`endif
        end
    end

    assign live_count = live_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_index <= res_index;
            out_err   <= res_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_otp_stream_cipher.sv
// Directed, table-driven bench for otp_stream_cipher (DATA_W=8, PAD_DEPTH=8, SEED=1).
// Expectations follow OTP_BURN_EN when it is defined for the build.
module tb_otp_stream_cipher;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned PAD_DEPTH = 8;
    localparam int unsigned IDX_W     = 3;

`ifdef OTP_BURN_EN
    localparam bit BURN = 1'b1;
`else
    localparam bit BURN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [IDX_W-1:0]  in_index;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_err;
    logic [IDX_W:0]    live_count;

    int compared;
    int mismatched;

    otp_stream_cipher #(
        .DATA_W    (DATA_W),
        .PAD_DEPTH (PAD_DEPTH),
        .SEED      (8'h01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_index   (in_index),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_err    (out_err),
        .live_count (live_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              mode;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_data;
        logic [IDX_W-1:0]  exp_idx;
        logic              exp_err;
        logic [IDX_W:0]    exp_lc;
    } vec_t;

    vec_t vecs [8];

    // Galois LFSR (taps 0xB8) from seed 0x01, hand-stepped.
    logic [DATA_W-1:0] pads [9];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic [IDX_W-1:0] idx,
                                 input logic [DATA_W-1:0] data);
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = mode;
        in_index = idx;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_index  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkResult(input string name, input logic [DATA_W-1:0] d,
                               input logic [IDX_W-1:0] i, input logic e);
        checkOutput({name, ".valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, ".data"},  32'(out_data),  32'(d));
        checkOutput({name, ".index"}, 32'(out_index), 32'(i));
        checkOutput({name, ".err"},   32'(out_err),   32'(e));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_mode    = 1'b0;
        in_index   = '0;
        in_data    = '0;
        out_ready  = 1'b1;

        pads = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8, 8'h64};

        vecs[0] = '{1'b0, 3'd0, 8'h00, 8'h01, 3'd0, 1'b0, 4'd1};
        vecs[1] = '{1'b0, 3'd0, 8'hA5, 8'h1D, 3'd1, 1'b0, 4'd2};
        vecs[2] = '{1'b1, 3'd1, 8'h1D, 8'hA5, 3'd1, 1'b0, BURN ? 4'd1 : 4'd2};
        vecs[3] = '{1'b1, 3'd1, 8'h1D, BURN ? 8'h00 : 8'hA5, 3'd1, BURN, BURN ? 4'd1 : 4'd2};
        vecs[4] = '{1'b1, 3'd3, 8'h55, 8'h00, 3'd3, 1'b1, BURN ? 4'd1 : 4'd2};
        vecs[5] = '{1'b0, 3'd5, 8'h3C, 8'h60, 3'd2, 1'b0, BURN ? 4'd2 : 4'd3};
        vecs[6] = '{1'b1, 3'd2, 8'h60, 8'h3C, 3'd2, 1'b0, BURN ? 4'd1 : 4'd3};
        vecs[7] = '{1'b1, 3'd0, 8'h01, 8'h00, 3'd0, 1'b0, BURN ? 4'd0 : 4'd3};

        // Reset and idle
        doReset();
        @(negedge clk);
        checkOutput("idle.out_valid",  32'(out_valid),  32'd0);
        checkOutput("idle.in_ready",   32'(in_ready),   32'd1);
        checkOutput("idle.live_count", 32'(live_count), 32'd0);
        checkOutput("idle.out_data",   32'(out_data),   32'd0);

        // Table of single transactions, drained each cycle
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].mode, vecs[v].idx, vecs[v].data);
            checkResult($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_idx,
                        vecs[v].exp_err);
            checkOutput($sformatf("vec%0d.live_count", v), 32'(live_count),
                        32'(vecs[v].exp_lc));
        end

        // Back-to-back round trip: decrypt reads the pad written on the previous edge
        doReset();
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_index = 3'd6; in_data = 8'hA5;
        @(negedge clk);
        checkResult("rt.enc", 8'hA4, 3'd0, 1'b0);
        in_mode = 1'b1; in_index = 3'd0; in_data = 8'hA4;
        @(negedge clk);
        in_valid = 1'b0;
        checkResult("rt.dec", 8'hA5, 3'd0, 1'b0);
        checkOutput("rt.live_count", 32'(live_count), BURN ? 32'd0 : 32'd1);

        // Back-pressure with a pending encrypt held at the input
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'h00);
        in_valid = 1'b1; in_mode = 1'b0; in_data = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            checkResult($sformatf("bp.hold%0d", c), 8'h01, 3'd0, 1'b0);
            checkOutput($sformatf("bp.in_ready%0d", c), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkResult("bp.next", 8'h47, 3'd1, 1'b0);
        checkOutput("bp.live_count", 32'(live_count), 32'd2);

        // Exhaustion: nine encrypts, no decrypts
        doReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 3'd0, 8'h00);
            checkResult($sformatf("ex%0d", k), pads[k], 3'(k), 1'b0);
        end
        applyStimulus(1'b0, 3'd0, 8'h00);
        checkResult("ex8", BURN ? 8'h00 : pads[8], 3'd0, BURN);
        checkOutput("ex8.live_count", 32'(live_count), 32'd8);

        // Asynchronous reset while a result is stalled
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'h11);
        checkResult("ar.pre", 8'h10, 3'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("ar.out_valid",  32'(out_valid),  32'd0);
        checkOutput("ar.out_data",   32'(out_data),   32'd0);
        checkOutput("ar.out_index",  32'(out_index),  32'd0);
        checkOutput("ar.out_err",    32'(out_err),    32'd0);
        checkOutput("ar.live_count", 32'(live_count), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("ar.in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 3'd4, 8'h00);
        checkResult("ar.first_pad", 8'h01, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/otp_stream_cipher.md
# otp_stream_cipher

Parametrised one-time-pad cipher engine with valid/ready streaming on both sides. It generates pad words from an internal LFSR, stores each pad in a PAD_DEPTH-entry pad store tagged by slot index, and XORs it with the input word. Decrypt requests fetch a stored pad by index. It replaces the fixed 8-bit encryptor in the pad-based datapath, and sits between the I/O front end and any downstream consumer.

## Interface
- DATA_W, 8: data and pad word width; legal values are 8, 16 and 32.
- PAD_DEPTH, 8: number of pad slots; a power of two, 2..256. IDX_W = $clog2(PAD_DEPTH).
- SEED, 'h1: LFSR reset value; must be nonzero (elaboration error if zero).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- in_index  in  IDX_W  pad slot for decrypt; ignored on encrypt.
- in_data  in  DATA_W  plaintext (encrypt) or ciphertext (decrypt).
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  DATA_W  result word.
- out_index  out  IDX_W  slot used by this result.
- out_err  out  1  request refused; out_data is forced to 0.
- live_count  out  IDX_W+1  number of slots holding unconsumed pads.

## Operation
- State: LFSR (DATA_W bits), wr_ptr (IDX_W), pad store PAD_DEPTH x DATA_W, live[PAD_DEPTH], and one output register stage.
- LFSR: Galois, taps from the package per DATA_W. Advances exactly once per accepted encrypt that is not refused, and never otherwise.
- Accepted encrypt, slot wr_ptr writable:
  - Store the current LFSR value at wr_ptr and set live[wr_ptr].
  - Result: out_data = in_data ^ lfsr, out_index = wr_ptr, out_err = 0.
  - wr_ptr increments and wraps from PAD_DEPTH-1 to 0.
- Accepted decrypt, slot in_index readable:
  - Result: out_data = in_data ^ pad[in_index], out_index = in_index, out_err = 0.
- Refused request: out_valid is still raised, with out_err = 1, out_data = 0 and out_index = the requested slot. No state changes.
- Writable and readable conditions are defined under Configuration.
- live_count equals the popcount of live at all times. It is maintained incrementally and updated in the same cycle as live.

## Timing
- in_ready = ~out_valid | out_ready, combinational. There is no other combinational path from input to output.
- Latency: result registered one cycle after acceptance. Full throughput of one word per cycle while out_ready = 1.
- Holding rules:
  - out_valid, out_data, out_index and out_err hold stable while out_valid & ~out_ready.
  - in_* values are sampled only on the acceptance edge.
- Pad-store write and read-for-decrypt use the same edge. A decrypt accepted in the cycle after an encrypt to the same slot sees the new pad (write-then-read ordering; no bypass needed since writes commit on the acceptance edge).
- Reset values (asynchronous, immediate): out_valid 0, out_data 0, out_index 0, out_err 0, wr_ptr 0, all live 0, live_count 0, LFSR = SEED. Pad store contents are don't-care.
- Reset asserted mid-transfer discards any pending result. After release, in_ready = 1.

## Configuration
- OTP_BURN_EN defined (one-time enforcement):
  - Encrypt is writable only if ~live[wr_ptr]. Otherwise it is refused, and wr_ptr does not advance.
  - Decrypt is readable only if live[in_index]. A successful decrypt clears live[in_index], so a second decrypt of that slot is refused.
- OTP_BURN_EN undefined:
  - Encrypt is always writable and overwrites the oldest slot on wrap.
  - Decrypt is readable iff live[in_index]. live is never cleared after write, and out_err arises only for never-written slots.

## Structure
- Package otp_pkg holds:
  - the mode constants MODE_ENC/MODE_DEC;
  - a function lfsr_taps(width) returning 'hB8 (8), 'hB400 (16) and 'h80200003 (32).
- Sub-module otp_lfsr (params WIDTH, SEED; ports clk, rst, advance, value).
- Pad store and live flags are inferred flops in the top module.

## Test plan
- Reset, then idle: out_valid = 0, in_ready = 1, live_count = 0.
  - Encrypt 0x00 → out_data equals the LFSR value SEED ^ 0 = 0x01 (SEED = 1), out_index = 0, live_count = 1.
- Round trip: encrypt 0xA5 at slot 0.
  - Decrypt the result with index 0 → 0xA5, out_err = 0.
  - With OTP_BURN_EN, live_count returns to 0.
- Back-pressure: hold out_ready = 0 for 5 cycles after an encrypt.
  - Result stays stable and in_ready = 0.
  - The LFSR advances once only.
  - Next encrypt uses index 1.
- Burn:
  - OTP_BURN_EN: decrypt slot 0 twice → second result out_err = 1, out_data = 0.
  - Decrypt of unwritten slot 3 → out_err = 1 in both configurations.
- Exhaustion (PAD_DEPTH = 8): 9 encrypts with no decrypts.
  - OTP_BURN_EN: the 9th gives out_err = 1, index 0, live_count = 8.
  - Without it: the 9th succeeds at index 0 and overwrites.
- Asynchronous reset asserted while out_valid & ~out_ready → all outputs 0 immediately, live_count = 0, next encrypt reproduces the first pad.
